// File: rtl/bar_foo_operand_pairer_if.sv
// Handshake bundle for the operand pairer: word source side, pair sink side and status.
// slave is the pairer's view; master is the environment driving words and consuming pairs.
interface bar_foo_operand_pairer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_in1;
  logic [WIDTH-1:0] m_in2;
  logic [CW-1:0]    count;
  logic             half;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_in1, m_in2, count, half
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_in1, m_in2, count, half
  );
endinterface

// File: rtl/bar_foo_operand_pairer.sv
// Pairs consecutive operand words into (in1, in2) and buffers the pairs in a small
// first-word-fall-through FIFO feeding the bar_foo datapath stage.
module bar_foo_operand_pairer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input logic                     CLK,
  input logic                     ASYNCRESETN,
  bar_foo_operand_pairer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StHaveA = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               full;
  logic               s_xfer;
  logic               push;
  logic               pop;
  logic               s_ready;
  logic               m_valid;

  assign full = (count_q == CW'(DEPTH));

  // Ready depends on registered state only; m_ready never reaches s_ready.
  assign s_ready = ASYNCRESETN && ((state_q == StIdle) || !full);
  assign s_xfer  = bus.s_valid && s_ready;
  assign push    = s_xfer && (state_q == StHaveA);
  assign m_valid = (count_q != '0);
  assign pop     = m_valid && bus.m_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (s_xfer) begin
      if (state_q == StIdle) begin
        hold_d  = bus.s_data;
        state_d = StHaveA;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {hold_q, bus.s_data};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_in1   = m_valid ? mem_q[rd_ptr_q][2*WIDTH-1:WIDTH] : '0;
  assign bus.m_in2   = m_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
  assign bus.count   = count_q;
  assign bus.half    = (state_q == StHaveA);
endmodule

// File: tb/tb_bar_foo_operand_pairer.sv
// Randomised and directed bench for bar_foo_operand_pairer against a queue-based pair model.
module tb_bar_foo_operand_pairer;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic CLK = 1'b0;
  logic ASYNCRESETN;

  always #5 CLK = ~CLK;

  bar_foo_operand_pairer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  bar_foo_operand_pairer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: completed pairs in arrival order plus the held half-pair.
  logic [2*WIDTH-1:0] mq[$];
  bit                 m_half;
  logic [WIDTH-1:0]   m_hold;
  int                 m_pops;

  function automatic bit exp_ready();
    return !m_half || (mq.size() < DEPTH);
  endfunction

  function automatic logic [2*WIDTH-1:0] exp_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_half = 1'b0;
    m_hold = '0;
  endtask

  // One clock: predict transfers from current inputs, advance, update model.
  task automatic step();
    bit acc, pp;
    acc = bus.s_valid && exp_ready();
    pp  = (mq.size() != 0) && bus.m_ready;
    @(posedge CLK);
    if (pp) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (acc) begin
      if (m_half) begin
        mq.push_back({m_hold, bus.s_data});
        m_half = 1'b0;
      end else begin
        m_hold = bus.s_data;
        m_half = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'd7;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({bus.s_ready, bus.m_valid, bus.count, bus.half, bus.m_in1, bus.m_in2} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: s_ready=%0b m_valid=%0b count=%0d half=%0b in1=%0d in2=%0d, expected all 0",
               bus.s_ready, bus.m_valid, bus.count, bus.half, bus.m_in1, bus.m_in2);
    end
    bus.s_valid = 1'b0;
    ASYNCRESETN = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %0b expected 1", bus.s_ready);
    end
  endtask

  task automatic test_basic_pair();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'd3;
    step();
    n_checks++;
    if (bus.half !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_first_word: half=%0b m_valid=%0b expected 1 0", bus.half, bus.m_valid);
    end
    bus.s_data = 4'd5;
    step();
    bus.s_valid = 1'b0;
    n_checks++;
    if ({bus.m_valid, bus.m_in1, bus.m_in2, bus.count, bus.half} !== {1'b1, 4'd3, 4'd5, 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_pair_out: valid=%0b in1=%0d in2=%0d count=%0d half=%0b expected 1 3 5 1 0",
               bus.m_valid, bus.m_in1, bus.m_in2, bus.count, bus.half);
    end
    step();
    n_checks++;
    if ({bus.m_valid, bus.count, bus.m_in1, bus.m_in2} !== '0) begin
      n_fail++;
      $display("FAIL basic_drained: valid=%0b count=%0d in1=%0d in2=%0d expected 0 0 0 0",
               bus.m_valid, bus.count, bus.m_in1, bus.m_in2);
    end
  endtask

  task automatic test_fill_full();
    bus.m_ready = 1'b0;
    for (int w = 1; w <= 9; w++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = WIDTH'(w);
      n_checks++;
      if (bus.s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ready_word%0d: got %0b expected 1", w, bus.s_ready);
      end
      step();
      if (w == 8) begin
        n_checks++;
        if (bus.count !== CW'(4) || bus.half !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_full_count: count=%0d half=%0b expected 4 0", bus.count, bus.half);
        end
      end
    end
    bus.s_data = 4'd10;
    repeat (3) step();
    n_checks++;
    if ({bus.count, bus.half, bus.s_ready} !== {3'd4, 1'b1, 1'b0} || !m_half || m_hold != 4'd9) begin
      n_fail++;
      $display("FAIL fill_stalled: count=%0d half=%0b s_ready=%0b expected 4 1 0",
               bus.count, bus.half, bus.s_ready);
    end
  endtask

  task automatic test_pop_from_full();
    logic [WIDTH-1:0] e1, e2;
    n_checks++;
    if (bus.m_in1 !== 4'd1 || bus.m_in2 !== 4'd2) begin
      n_fail++;
      $display("FAIL full_head: in1=%0d in2=%0d expected 1 2", bus.m_in1, bus.m_in2);
    end
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    n_checks++;
    if ({bus.count, bus.s_ready, bus.half} !== {3'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL pop_full_after: count=%0d s_ready=%0b half=%0b expected 3 1 1",
               bus.count, bus.s_ready, bus.half);
    end
    step();
    bus.s_valid = 1'b0;
    n_checks++;
    if (bus.count !== CW'(4) || bus.half !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_full_refill: count=%0d half=%0b expected 4 0", bus.count, bus.half);
    end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e1 = WIDTH'(3 + 2 * k);
      e2 = WIDTH'(4 + 2 * k);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_in1 !== e1 || bus.m_in2 !== e2) begin
        n_fail++;
        $display("FAIL drain_pair%0d: valid=%0b in1=%0d in2=%0d expected 1 %0d %0d",
                 k, bus.m_valid, bus.m_in1, bus.m_in2, e1, e2);
      end
      step();
    end
    n_checks++;
    if (bus.count !== '0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: count=%0d valid=%0b expected 0 0", bus.count, bus.m_valid);
    end
  endtask

  task automatic test_back_to_back();
    int np;
    logic [2*WIDTH-1:0] ep;
    np = 0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus.s_valid = (i < 16);
      bus.s_data  = WIDTH'(i);
      n_checks++;
      if (bus.count > CW'(1)) begin
        n_fail++;
        $display("FAIL stream_count_cycle%0d: got %0d expected <= 1", i, bus.count);
      end
      if (bus.m_valid === 1'b1) begin
        ep = {WIDTH'(2 * np), WIDTH'(2 * np + 1)};
        n_checks++;
        if ({bus.m_in1, bus.m_in2} !== ep) begin
          n_fail++;
          $display("FAIL stream_pair%0d: got %0d,%0d expected %0d,%0d",
                   np, bus.m_in1, bus.m_in2, ep[2*WIDTH-1:WIDTH], ep[WIDTH-1:0]);
        end
        np++;
      end
      step();
    end
    n_checks++;
    if (np != 8 || bus.count !== '0) begin
      n_fail++;
      $display("FAIL stream_total: pairs=%0d count=%0d expected 8 0", np, bus.count);
    end
  endtask

  task automatic test_random();
    bit               stall_prev;
    logic [2*WIDTH-1:0] data_prev;
    logic [2*WIDTH-1:0] eh;
    stall_prev = 1'b0;
    data_prev  = '0;
    for (int c = 0; c < 400; c++) begin
      bus.s_valid = ($urandom_range(0, 1) == 1);
      bus.s_data  = WIDTH'($urandom);
      bus.m_ready = ($urandom_range(0, 1) == 1);
      eh = exp_head();
      n_checks++;
      if ({bus.s_ready, bus.m_valid, bus.count, bus.half, bus.m_in1, bus.m_in2} !==
          {exp_ready(), mq.size() != 0, CW'(mq.size()), m_half, eh}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: rdy=%0b vld=%0b cnt=%0d half=%0b in=%0d,%0d expected %0b %0b %0d %0b %0d,%0d",
                 c, bus.s_ready, bus.m_valid, bus.count, bus.half, bus.m_in1, bus.m_in2,
                 exp_ready(), mq.size() != 0, mq.size(), m_half,
                 eh[2*WIDTH-1:WIDTH], eh[WIDTH-1:0]);
      end
      if (stall_prev) begin
        n_checks++;
        if ({bus.m_in1, bus.m_in2} !== data_prev) begin
          n_fail++;
          $display("FAIL random_hold%0d: got %0d,%0d expected %0d,%0d", c, bus.m_in1, bus.m_in2,
                   data_prev[2*WIDTH-1:WIDTH], data_prev[WIDTH-1:0]);
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      data_prev  = {bus.m_in1, bus.m_in2};
      step();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_async_reset();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      bus.s_data = WIDTH'(w);
      step();
    end
    bus.s_valid = 1'b0;
    n_checks++;
    if (bus.count !== CW'(2) || bus.half !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_setup: count=%0d half=%0b expected 2 1", bus.count, bus.half);
    end
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    n_checks++;
    if ({bus.s_ready, bus.m_valid, bus.count, bus.half, bus.m_in1, bus.m_in2} !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: rdy=%0b vld=%0b cnt=%0d half=%0b in=%0d,%0d expected all 0",
               bus.s_ready, bus.m_valid, bus.count, bus.half, bus.m_in1, bus.m_in2);
    end
    model_clear();
    @(posedge CLK);
    #1;
    ASYNCRESETN = 1'b1;
    #1;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'hA;
    step();
    bus.s_data  = 4'hB;
    step();
    bus.s_valid = 1'b0;
    n_checks++;
    if ({bus.m_valid, bus.count, bus.m_in1, bus.m_in2} !== {1'b1, 3'd1, 4'hA, 4'hB}) begin
      n_fail++;
      $display("FAIL areset_fresh_pair: vld=%0b cnt=%0d in=%0h,%0h expected 1 1 a,b",
               bus.m_valid, bus.count, bus.m_in1, bus.m_in2);
    end
    step();
    n_checks++;
    if (bus.count !== '0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_fresh_drain: cnt=%0d vld=%0b expected 0 0", bus.count, bus.m_valid);
    end
  endtask

  initial begin
    m_pops = 0;
    model_clear();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic_pair();
    test_fill_full();
    test_pop_from_full();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
